// File: rtl/pipe_skid_stage.sv
// Generic inter-stage register: valid/ready handshake with a 2-entry skid buffer.
// Optional statistics counters are enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_stage #(
  parameter int DATA_W      = 108,
  parameter bit BUBBLE_ZERO = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t              r_state, w_nxt;
  logic [DATA_W-1:0]   r_main_d, r_skid_d;
  logic                w_main_v, w_skid_v, w_acc, w_take;
  logic                w_ld_main_in, w_ld_main_skid, w_ld_skid;
  logic                w_clr_main, w_clr_skid;

  assign w_main_v  = (r_state != S_EMPTY);
  assign w_skid_v  = (r_state == S_TWO);

  // in_ready depends only on local state and flush, never on out_ready
  assign in_ready  = ~w_skid_v & ~flush;
  assign out_valid = w_main_v & ~flush;
  assign out_data  = r_main_d;

  assign w_acc  = in_valid & in_ready;
  assign w_take = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt          = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_main     = 1'b0;
    w_clr_skid     = 1'b0;
    if (flush) begin
      w_nxt      = S_EMPTY;
      w_clr_main = 1'b1;
      w_clr_skid = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) begin
          w_nxt        = S_ONE;
          w_ld_main_in = 1'b1;
        end
        S_ONE: begin
          if (w_acc && w_take) begin
            w_ld_main_in = 1'b1;
          end else if (w_acc) begin
            w_nxt     = S_TWO;
            w_ld_skid = 1'b1;
          end else if (w_take) begin
            w_nxt      = S_EMPTY;
            w_clr_main = 1'b1;
          end
        end
        S_TWO: if (w_take) begin
          w_nxt          = S_ONE;
          w_ld_main_skid = 1'b1;
          w_clr_skid     = 1'b1;
        end
        default: w_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_d <= '0;
      r_skid_d <= '0;
    end else begin
      if (w_ld_main_in)                   r_main_d <= in_data;
      else if (w_ld_main_skid)            r_main_d <= r_skid_d;
      else if (w_clr_main && BUBBLE_ZERO) r_main_d <= '0;

      if (w_ld_skid)                      r_skid_d <= in_data;
      else if (w_clr_skid && BUBBLE_ZERO) r_skid_d <= '0;
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  // Qualified on the flush-gated out_valid; flush does not clear the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!out_valid && (r_bubble_cnt != '1))             r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, stats sequence, then random
// traffic checked against a queue-based reference model.
module tb_pipe_skid_stage;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0]  stall_cnt, bubble_cnt;
  logic         in_ready2, out_valid2;
  logic [W-1:0] out_data2;
  logic [1:0]   stall2, bubble2;
`endif

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(W), .BUBBLE_ZERO(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef PIPE_SKID_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_SKID_STATS_EN
  pipe_skid_stage #(.DATA_W(W), .BUBBLE_ZERO(1'b1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .stall_cnt(stall2), .bubble_cnt(bubble2)
  );
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO of held beats (at most 2) plus saturating counters
  logic [W-1:0] mq[$];
  int m_st = 0, m_bb = 0, m_st2 = 0, m_bb2 = 0;

  task automatic model_tick();
    bit ov, acc, take;
    ov   = (mq.size() > 0) && !flush;
    acc  = in_valid && (mq.size() < 2) && !flush;
    take = ov && out_ready;
    if (rst) begin
      mq.delete();
      m_st = 0; m_bb = 0; m_st2 = 0; m_bb2 = 0;
    end else begin
      if (ov && !out_ready) begin
        if (m_st  < 65535) m_st++;
        if (m_st2 < 3)     m_st2++;
      end
      if (!ov) begin
        if (m_bb  < 65535) m_bb++;
        if (m_bb2 < 3)     m_bb2++;
      end
      if (flush) mq.delete();
      else begin
        if (take) void'(mq.pop_front());
        if (acc)  mq.push_back(in_data);
      end
    end
  endtask

  task automatic model_check(input int cyc);
    logic [W-1:0] exp_d;
    exp_d = (mq.size() > 0) ? mq[0] : '0;
    check($sformatf("rnd_in_ready@%0d", cyc), in_ready, (mq.size() < 2) && !flush);
    check($sformatf("rnd_out_valid@%0d", cyc), out_valid, (mq.size() > 0) && !flush);
    check($sformatf("rnd_out_data@%0d", cyc), out_data, exp_d);
`ifdef PIPE_SKID_STATS_EN
    check($sformatf("rnd_stall_cnt@%0d", cyc), stall_cnt, m_st);
    check($sformatf("rnd_bubble_cnt@%0d", cyc), bubble_cnt, m_bb);
    check($sformatf("rnd_stall2@%0d", cyc), stall2, m_st2);
    check($sformatf("rnd_bubble2@%0d", cyc), bubble2, m_bb2);
`endif
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                       input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  typedef struct {
    logic         r, f, iv;
    logic [W-1:0] d;
    logic         ordy, chk, e_ir, e_ov;
    logic [W-1:0] e_od;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                              input logic ordy, input logic chk, input logic e_ir,
                              input logic e_ov, input logic [W-1:0] e_od);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    tbl.push_back(v);
  endfunction

  initial begin
    // Each row: inputs applied this cycle, expected outputs before the next edge
    add(1,0,0,0,0, 0, 0,0,0);
    add(1,0,0,0,0, 1, 1,0,0);
    add(0,0,0,0,1, 1, 1,0,0);
    for (int i = 1; i <= 8; i++) add(0,0,1,W'(i),1, 1, 1,(i > 1),W'(i-1));
    add(0,0,0,0,1, 1, 1,1,16'h8);
    add(0,0,0,0,1, 1, 1,0,0);
    // backpressure: A main, B skid, C held upstream
    add(0,0,1,16'hA,0, 1, 1,0,0);
    add(0,0,1,16'hB,0, 1, 1,1,16'hA);
    add(0,0,1,16'hC,0, 1, 0,1,16'hA);
    add(0,0,1,16'hC,1, 1, 0,1,16'hA);
    add(0,0,1,16'hC,1, 1, 1,1,16'hB);
    add(0,0,0,0,1,     1, 1,1,16'hC);
    add(0,0,0,0,1,     1, 1,0,0);
    // flush in state TWO with a beat presented
    add(0,0,1,16'h11,0, 1, 1,0,0);
    add(0,0,1,16'h22,0, 1, 1,1,16'h11);
    add(0,1,1,16'h33,0, 1, 0,0,16'h11);
    add(0,0,0,0,1,      1, 1,0,0);
    add(0,0,0,0,1,      1, 1,0,0);
    // reset in state TWO, then a fresh beat
    add(0,0,1,16'h11,0, 1, 1,0,0);
    add(0,0,1,16'h22,0, 1, 1,1,16'h11);
    add(1,0,1,16'h55,0, 1, 0,1,16'h11);
    add(0,0,1,16'h44,1, 1, 1,0,0);
    add(0,0,0,0,1,      1, 1,1,16'h44);
    add(0,0,0,0,1,      1, 1,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      if (tbl[i].chk) begin
        check($sformatf("tbl_in_ready[%0d]", i), in_ready, tbl[i].e_ir);
        check($sformatf("tbl_out_valid[%0d]", i), out_valid, tbl[i].e_ov);
        check($sformatf("tbl_out_data[%0d]", i), out_data, tbl[i].e_od);
      end
      step();
    end

`ifdef PIPE_SKID_STATS_EN
    drive(1,0,0,0,0); step(); step();
    drive(0,0,0,0,0);
    check("stats_reset_stall", stall_cnt, 0);
    check("stats_reset_bubble", bubble_cnt, 0);
    drive(0,0,1,16'h7,0); step();                  // fill: one bubble cycle
    for (int i = 0; i < 5; i++) begin drive(0,0,0,0,0); step(); end
    drive(0,0,0,0,0);
    check("stats_stall5", stall_cnt, 5);
    check("stats_sat_stall_w2", stall2, 3);
    step();
    drive(0,0,0,0,0);
    check("stats_stall6", stall_cnt, 6);
    check("stats_sat_hold_w2", stall2, 3);
    drive(0,0,0,0,1); step();                      // drain: neither counter moves
    for (int i = 0; i < 3; i++) begin drive(0,0,0,0,1); step(); end
    drive(0,0,0,0,1);
    check("stats_bubble_1p3", bubble_cnt, 4);
    check("stats_sat_bubble_w2", bubble2, 3);
`endif

    drive(1,0,0,0,0); step();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 70), W'($urandom), ($urandom_range(0, 99) < 65));
      model_check(c);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
